// File: rtl/key_pkg.sv
// Shared types and defaults for the key debouncer.
// Latency: none (declarations only); backpressure: none.
package key_pkg;

  typedef enum logic [1:0] {
    UP        = 2'd0,
    WAIT_DOWN = 2'd1,
    DOWN      = 2'd2,
    WAIT_UP   = 2'd3
  } key_state_t;

  localparam int DEF_TICK_DIV       = 50000;
  localparam int DEF_STABLE_SAMPLES = 20;

  // Index width that stays legal for a single-key build.
  function automatic int idx_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/key_debounce_if.sv
// Key pins in, debounced level/pulse/priority outputs back to the consumer.
// Latency: none (wiring only); backpressure: none, all outputs are free-running.
interface key_debounce_if #(
  parameter int NUM_KEYS = 4
) ();
  import key_pkg::*;

  localparam int IDX_W = idx_w(NUM_KEYS);

  logic [NUM_KEYS-1:0] key_in;
  logic [NUM_KEYS-1:0] key_level;
  logic [NUM_KEYS-1:0] key_press;
  logic [NUM_KEYS-1:0] key_release;
  logic                any_press;
  logic [IDX_W-1:0]    last_key;

  modport master (
    input  key_in,
    output key_level, key_press, key_release, any_press, last_key
  );

  modport slave (
    output key_in,
    input  key_level, key_press, key_release, any_press, last_key
  );
endinterface

// File: rtl/key_debounce_fsm.sv
// One key: 2-flop synchroniser, tick-sampled stability FSM, registered pulses.
// Latency: 2 + TICK_DIV*STABLE_SAMPLES + 1 clk worst case; backpressure: none.
module key_debounce_fsm
  import key_pkg::*;
#(
  parameter int STABLE_SAMPLES = DEF_STABLE_SAMPLES,
  parameter bit KEY_ACTIVE_LOW = 1'b1
) (
  input  logic clk,
  input  logic rst_n,
  input  logic tick,
  input  logic key_raw,
  output logic key_level,
  output logic key_press,
  output logic key_release,
  output logic press_nxt
);

  localparam int              CNT_W    = $clog2(STABLE_SAMPLES + 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(STABLE_SAMPLES - 1);
  localparam logic [CNT_W-1:0] CNT_MAX  = CNT_W'(STABLE_SAMPLES);
  localparam logic             IDLE_LVL = KEY_ACTIVE_LOW;

  logic             sync1_q, sync1_d;
  logic             sync2_q, sync2_d;
  key_state_t       state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             level_q, level_d;
  logic             press_q, press_d;
  logic             release_q, release_d;
  logic             sample;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      sync1_q   <= IDLE_LVL;
      sync2_q   <= IDLE_LVL;
      state_q   <= UP;
      cnt_q     <= '0;
      level_q   <= 1'b0;
      press_q   <= 1'b0;
      release_q <= 1'b0;
    end else begin
      sync1_q   <= sync1_d;
      sync2_q   <= sync2_d;
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      level_q   <= level_d;
      press_q   <= press_d;
      release_q <= release_d;
    end
  end

  always_comb begin
    sync1_d = key_raw;
    sync2_d = sync1_q;
    sample  = KEY_ACTIVE_LOW ? ~sync2_q : sync2_q;
  end

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    level_d   = level_q;
    press_d   = 1'b0;
    release_d = 1'b0;
    if (tick) begin
      case (state_q)
        UP: begin
          if (sample) begin
            if (STABLE_SAMPLES == 1) begin
              state_d = DOWN;
              level_d = 1'b1;
              press_d = 1'b1;
            end else begin
              state_d = WAIT_DOWN;
              cnt_d   = CNT_W'(1);
            end
          end
        end
        WAIT_DOWN: begin
          if (!sample) begin
            // Bounce: abandon the candidate press silently.
            state_d = UP;
            cnt_d   = '0;
          end else if (cnt_q == CNT_LAST) begin
            state_d = DOWN;
            cnt_d   = '0;
            level_d = 1'b1;
            press_d = 1'b1;
          end else begin
            cnt_d = (cnt_q == CNT_MAX) ? cnt_q : cnt_q + CNT_W'(1);
          end
        end
        DOWN: begin
          if (!sample) begin
            if (STABLE_SAMPLES == 1) begin
              state_d   = UP;
              level_d   = 1'b0;
              release_d = 1'b1;
            end else begin
              state_d = WAIT_UP;
              cnt_d   = CNT_W'(1);
            end
          end
        end
        WAIT_UP: begin
          if (sample) begin
            state_d = DOWN;
            cnt_d   = '0;
          end else if (cnt_q == CNT_LAST) begin
            state_d   = UP;
            cnt_d     = '0;
            level_d   = 1'b0;
            release_d = 1'b1;
          end else begin
            cnt_d = (cnt_q == CNT_MAX) ? cnt_q : cnt_q + CNT_W'(1);
          end
        end
        default: begin
          state_d = UP;
          cnt_d   = '0;
        end
      endcase
    end
  end

  assign key_level   = level_q;
  assign key_press   = press_q;
  assign key_release = release_q;
  assign press_nxt   = press_d;

endmodule

// File: rtl/key_debounce.sv
// Shared sample tick, per-key debounce FSMs, any_press / last_key priority.
// Latency: 2 + TICK_DIV*STABLE_SAMPLES + 1 clk worst case; backpressure: none.
module key_debounce
  import key_pkg::*;
#(
  parameter int NUM_KEYS       = 4,
  parameter int TICK_DIV       = DEF_TICK_DIV,
  parameter int STABLE_SAMPLES = DEF_STABLE_SAMPLES,
  parameter bit KEY_ACTIVE_LOW = 1'b1
) (
  input  logic           clk,
  input  logic           rst_n,
  key_debounce_if.master kb
);

  localparam int TW    = $clog2(TICK_DIV);
  localparam int IDX_W = idx_w(NUM_KEYS);

  logic [TW-1:0]       tick_cnt_q, tick_cnt_d;
  logic                tick;
  logic [NUM_KEYS-1:0] level, press, rel, press_nxt;
  logic                any_press_q, any_press_d;
  logic [IDX_W-1:0]    last_key_q, last_key_d;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      tick_cnt_q  <= '0;
      any_press_q <= 1'b0;
      last_key_q  <= '0;
    end else begin
      tick_cnt_q  <= tick_cnt_d;
      any_press_q <= any_press_d;
      last_key_q  <= last_key_d;
    end
  end

  always_comb begin
    tick       = (tick_cnt_q == TW'(TICK_DIV - 1));
    tick_cnt_d = tick ? '0 : tick_cnt_q + TW'(1);
  end

  for (genvar i = 0; i < NUM_KEYS; i++) begin : g_key
    key_debounce_fsm #(
      .STABLE_SAMPLES (STABLE_SAMPLES),
      .KEY_ACTIVE_LOW (KEY_ACTIVE_LOW)
    ) u_fsm (
      .clk         (clk),
      .rst_n       (rst_n),
      .tick        (tick),
      .key_raw     (kb.key_in[i]),
      .key_level   (level[i]),
      .key_press   (press[i]),
      .key_release (rel[i]),
      .press_nxt   (press_nxt[i])
    );
  end

  // Built from next-cycle press flags so any_press/last_key land with key_press.
  always_comb begin
    any_press_d = |press_nxt;
    last_key_d  = last_key_q;
    for (int i = NUM_KEYS - 1; i >= 0; i--) begin
      if (press_nxt[i]) last_key_d = IDX_W'(i);
    end
  end

  assign kb.key_level   = level;
  assign kb.key_press   = press;
  assign kb.key_release = rel;
  assign kb.any_press   = any_press_q;
  assign kb.last_key    = last_key_q;

endmodule

// File: tb/tb_key_debounce.sv
// Drives a STABLE_SAMPLES=3 and a STABLE_SAMPLES=1 build from the same pins and
// compares both every cycle against a run-length reference model.
module tb_key_debounce;
  import key_pkg::*;

  localparam int NK = 4;
  localparam int TD = 4;
  localparam int SS = 3;

  logic          clk = 1'b0;
  logic          rst_n;
  logic [NK-1:0] key_in;

  always #5 clk = ~clk;

  key_debounce_if #(.NUM_KEYS(NK)) if3 ();
  key_debounce_if #(.NUM_KEYS(NK)) if1 ();
  assign if3.key_in = key_in;
  assign if1.key_in = key_in;

  key_debounce #(.NUM_KEYS(NK), .TICK_DIV(TD), .STABLE_SAMPLES(SS), .KEY_ACTIVE_LOW(1'b1))
    dut3 (.clk(clk), .rst_n(rst_n), .kb(if3));
  key_debounce #(.NUM_KEYS(NK), .TICK_DIV(TD), .STABLE_SAMPLES(1), .KEY_ACTIVE_LOW(1'b1))
    dut1 (.clk(clk), .rst_n(rst_n), .kb(if1));

  int n_vec = 0;
  int n_err = 0;

  // Reference: index 0 models the SS build, index 1 the single-sample build.
  int            need [2] = '{SS, 1};
  int            m_tick [2];
  int            m_run [2][NK];
  logic [NK-1:0] m_level [2];
  logic [NK-1:0] m_press [2];
  logic [NK-1:0] m_rel [2];
  logic [NK-1:0] m_hist0 [2];
  logic [NK-1:0] m_hist1 [2];
  logic          m_any [2];
  int            m_last [2];

  int cnt_p2, cnt_r2, cnt_any, cnt_p0, cnt_r0, cnt_lvl0, cnt_p1010;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s @%0t: got %0h expected %0h", tag, $time, obs, exp);
    end
  endtask

  // Advance the model across the coming clock edge using the current pins.
  task automatic model_edge();
    logic [NK-1:0] pressed;
    logic          tk;
    pressed = ~key_in;
    for (int m = 0; m < 2; m++) begin
      if (!rst_n) begin
        m_tick[m]  = 0;
        m_level[m] = '0;
        m_press[m] = '0;
        m_rel[m]   = '0;
        m_any[m]   = 1'b0;
        m_last[m]  = 0;
        m_hist0[m] = '0;
        m_hist1[m] = '0;
        for (int k = 0; k < NK; k++) m_run[m][k] = 0;
      end else begin
        tk         = (m_tick[m] == TD - 1);
        m_press[m] = '0;
        m_rel[m]   = '0;
        if (tk) begin
          for (int k = 0; k < NK; k++) begin
            if (m_hist1[m][k] != m_level[m][k]) m_run[m][k]++;
            else m_run[m][k] = 0;
            if (m_run[m][k] == need[m]) begin
              m_level[m][k] = ~m_level[m][k];
              if (m_level[m][k]) m_press[m][k] = 1'b1;
              else m_rel[m][k] = 1'b1;
              m_run[m][k] = 0;
            end
          end
        end
        m_tick[m]  = (m_tick[m] + 1) % TD;
        m_hist1[m] = m_hist0[m];
        m_hist0[m] = pressed;
        m_any[m]   = |m_press[m];
        for (int k = NK - 1; k >= 0; k--) if (m_press[m][k]) m_last[m] = k;
      end
    end
  endtask

  task automatic check_outputs();
    chk("s3.level",   32'(if3.key_level),   32'(m_level[0]));
    chk("s3.press",   32'(if3.key_press),   32'(m_press[0]));
    chk("s3.release", 32'(if3.key_release), 32'(m_rel[0]));
    chk("s3.any",     32'(if3.any_press),   32'(m_any[0]));
    chk("s3.last",    32'(if3.last_key),    32'(m_last[0]));
    chk("s3.tickcnt", 32'(dut3.tick_cnt_q), 32'(m_tick[0]));
    chk("s1.level",   32'(if1.key_level),   32'(m_level[1]));
    chk("s1.press",   32'(if1.key_press),   32'(m_press[1]));
    chk("s1.release", 32'(if1.key_release), 32'(m_rel[1]));
    chk("s1.any",     32'(if1.any_press),   32'(m_any[1]));
    chk("s1.last",    32'(if1.last_key),    32'(m_last[1]));
    chk("s1.tickcnt", 32'(dut1.tick_cnt_q), 32'(m_tick[1]));
  endtask

  task automatic cycle();
    model_edge();
    @(posedge clk);
    @(negedge clk);
    check_outputs();
    cnt_p2    += int'(if3.key_press[2]);
    cnt_r2    += int'(if3.key_release[2]);
    cnt_any   += int'(if3.any_press);
    cnt_p0    += int'(if3.key_press[0]);
    cnt_r0    += int'(if3.key_release[0]);
    cnt_lvl0  += int'(if3.key_level[0]);
    cnt_p1010 += int'(if3.key_press == 4'b1010);
  endtask

  task automatic run(input int n);
    repeat (n) cycle();
  endtask

  task automatic clr();
    cnt_p2 = 0; cnt_r2 = 0; cnt_any = 0; cnt_p0 = 0;
    cnt_r0 = 0; cnt_lvl0 = 0; cnt_p1010 = 0;
  endtask

  initial begin
    int press_at;
    int div;
    clr();
    rst_n  = 1'b0;
    key_in = '1;
    run(3);
    rst_n = 1'b1;
    run(10);

    // Clean press and release on key 2.
    clr();
    key_in[2] = 1'b0;
    run(40);
    chk("clean.level2", 32'(if3.key_level[2]), 32'd1);
    chk("clean.last",   32'(if3.last_key),     32'd2);
    key_in[2] = 1'b1;
    run(40);
    chk("clean.npress",   32'(cnt_p2),  32'd1);
    chk("clean.nrelease", 32'(cnt_r2),  32'd1);
    chk("clean.nany",     32'(cnt_any), 32'd1);
    chk("clean.level2_off", 32'(if3.key_level[2]), 32'd0);

    // Bouncing key 0 never qualifies.
    clr();
    key_in[0] = 1'b0; run(6);
    key_in[0] = 1'b1; run(6);
    key_in[0] = 1'b0; run(6);
    key_in[0] = 1'b1; run(30);
    chk("bounce.npress",   32'(cnt_p0),   32'd0);
    chk("bounce.nrelease", 32'(cnt_r0),   32'd0);
    chk("bounce.level",    32'(cnt_lvl0), 32'd0);

    // Keys 1 and 3 together.
    clr();
    key_in = 4'b0101;
    run(40);
    chk("simul.n1010", 32'(cnt_p1010), 32'd1);
    chk("simul.nany",  32'(cnt_any),   32'd1);
    chk("simul.last",  32'(if3.last_key), 32'd1);
    key_in = '1;
    run(40);

    // Reset after two qualifying ticks; must re-qualify from scratch.
    while (m_tick[0] != 0) cycle();
    key_in[0] = 1'b0;
    run(2 * TD);
    rst_n = 1'b0;
    run(2);
    chk("rst.level", 32'(if3.key_level), 32'd0);
    chk("rst.press", 32'(if3.key_press), 32'd0);
    chk("rst.last",  32'(if3.last_key),  32'd0);
    rst_n    = 1'b1;
    press_at = 0;
    for (int k = 1; k <= 40; k++) begin
      cycle();
      if (press_at == 0 && if3.key_press[0]) press_at = k;
    end
    chk("rst.press_at", 32'(press_at), 32'(SS * TD));
    key_in = '1;
    run(40);

    // Random pins at three toggle rates, with occasional resets.
    foreach (need[i]) begin end
    for (int ph = 0; ph < 3; ph++) begin
      div = (ph == 0) ? 4 : (ph == 1) ? 16 : 40;
      repeat (1200) begin
        for (int k = 0; k < NK; k++)
          if ($urandom_range(0, div - 1) == 0) key_in[k] = ~key_in[k];
        rst_n = ($urandom_range(0, 399) != 0);
        cycle();
      end
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
